// File: rtl/npi_mem_responder.sv
//------------------------------------------------------------------------------
// npi_mem_responder
//
// NPI target that answers personality-interface (PI_*) transactions from an
// NPI initiator out of an internal byte-enabled block RAM. Single clock,
// synchronous active-high reset.
//
// Ports
//   MPMC_Clk / MPMC_Rst        clock, synchronous active-high reset
//   PI_Addr/AddrReq/AddrAck    address handshake (ack is a one-cycle pulse)
//   PI_RNW, PI_Size            direction and transfer size (0:1, 1:4, 2:8,
//                              3+:16 words); PI_RdModWr is ignored
//   PI_InitDone                high once the post-reset init delay expires
//   PI_WrFIFO_*                16-deep write-data FIFO (data + byte enables)
//   PI_RdFIFO_*                16-deep first-word-fall-through read FIFO with
//                              per-word line-offset tag; latency constant 0
//
// Cache-line transfers (Size 1/2) start at the requested word and wrap inside
// the aligned line; 16-word bursts always start at the aligned line base.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module npi_mem_responder #(
    parameter int          C_PI_ADDR_WIDTH     = 32,
    parameter int          C_PI_DATA_WIDTH     = 32,
    parameter int          C_PI_BE_WIDTH       = 4,
    parameter int          C_PI_RDWDADDR_WIDTH = 4,
    parameter logic [31:0] C_PI_BASEADDR       = 32'hc0000000,
    parameter int          C_MEM_AWIDTH        = 10,
    parameter int          C_INIT_CYCLES       = 16
) (
    input  logic                           MPMC_Clk,
    input  logic                           MPMC_Rst,
    input  logic [C_PI_ADDR_WIDTH-1:0]     PI_Addr,
    input  logic                           PI_AddrReq,
    output logic                           PI_AddrAck,
    input  logic                           PI_RNW,
    input  logic                           PI_RdModWr,
    input  logic [3:0]                     PI_Size,
    output logic                           PI_InitDone,
    input  logic [C_PI_DATA_WIDTH-1:0]     PI_WrFIFO_Data,
    input  logic [C_PI_BE_WIDTH-1:0]       PI_WrFIFO_BE,
    input  logic                           PI_WrFIFO_Push,
    output logic                           PI_WrFIFO_AlmostFull,
    output logic                           PI_WrFIFO_Empty,
    input  logic                           PI_WrFIFO_Flush,
    output logic [C_PI_DATA_WIDTH-1:0]     PI_RdFIFO_Data,
    output logic [C_PI_RDWDADDR_WIDTH-1:0] PI_RdFIFO_RdWdAddr,
    input  logic                           PI_RdFIFO_Pop,
    output logic                           PI_RdFIFO_Empty,
    input  logic                           PI_RdFIFO_Flush,
    output logic [1:0]                     PI_RdFIFO_Latency
);

    localparam int DW         = C_PI_DATA_WIDTH;
    localparam int BW         = C_PI_BE_WIDTH;
    localparam int AW         = C_MEM_AWIDTH;
    localparam int FIFO_DEPTH = 16;
    localparam int MEM_DEPTH  = 2 ** AW;
    localparam int WF_W       = DW + BW;
    localparam int RF_W       = DW + 4;
    localparam logic [15:0] INIT_LAST = (C_INIT_CYCLES > 0) ? 16'(C_INIT_CYCLES - 1) : 16'd0;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD_FETCH, ST_WR_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [15:0]    init_cnt_q, init_cnt_d;
    logic           ack_q, ack_d;
    logic [4:0]     len_q, len_d;
    logic [4:0]     beat_q, beat_d;
    logic [3:0]     mask_q, mask_d;
    logic [3:0]     off_q, off_d;
    logic [AW-1:0]  base_q, base_d;
    logic           rdv_q, rdv_d;          // RAM read data valid this cycle
    logic [3:0]     rdv_tag_q, rdv_tag_d;  // line offset of that data

    // request decode
    logic [C_PI_ADDR_WIDTH-1:0] addr_rel;
    logic [AW-1:0]  req_word;
    logic [4:0]     req_len;
    logic [3:0]     req_mask;
    logic [3:0]     req_off;

    // write FIFO
    logic [WF_W-1:0] wf_mem [FIFO_DEPTH];
    logic [3:0]     wf_wptr_q, wf_wptr_d, wf_rptr_q, wf_rptr_d;
    logic [4:0]     wf_cnt_q, wf_cnt_d;
    logic           wf_push, wf_pop;
    logic [WF_W-1:0] wf_head;
    logic [DW-1:0]  wf_head_data;
    logic [BW-1:0]  wf_head_be;

    // read FIFO
    logic [RF_W-1:0] rf_mem_q [FIFO_DEPTH];
    logic [3:0]     rf_wptr_q, rf_wptr_d, rf_rptr_q, rf_rptr_d;
    logic [4:0]     rf_cnt_q, rf_cnt_d;
    logic           rf_push, rf_pop;
    logic [RF_W-1:0] rf_head;

    // RAM port
    logic           ram_re, ram_we;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_rd_data;

    logic           unused_sigs;

    assign addr_rel = PI_Addr - C_PI_ADDR_WIDTH'(C_PI_BASEADDR);
    assign req_word = addr_rel[AW+1:2];
    assign unused_sigs = ^{PI_RdModWr, addr_rel};

    always_comb begin
        req_len  = 5'd16;
        req_mask = 4'd15;
        case (PI_Size)
            4'd0: begin req_len = 5'd1; req_mask = 4'd0; end
            4'd1: begin req_len = 5'd4; req_mask = 4'd3; end
            4'd2: begin req_len = 5'd8; req_mask = 4'd7; end
            default: ;
        endcase
        // only cache lines start mid-line; bursts start at the aligned base
        req_off = 4'd0;
        if (PI_Size == 4'd1 || PI_Size == 4'd2) begin
            req_off = req_word[3:0] & req_mask;
        end
    end

    // Word being addressed this beat: aligned line base plus wrapped offset.
    assign ram_addr = base_q | AW'(off_q & mask_q);

    assign wf_head      = wf_mem[wf_rptr_q];
    assign wf_head_data = wf_head[DW-1:0];
    assign wf_head_be   = wf_head[WF_W-1:DW];

    //--------------------------------------------------------------------------
    // Control FSM
    //--------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ack_d      = 1'b0;
        len_d      = len_q;
        beat_d     = beat_q;
        mask_d     = mask_q;
        off_d      = off_q;
        base_d     = base_q;
        rdv_d      = 1'b0;
        rdv_tag_d  = rdv_tag_q;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        wf_pop     = 1'b0;
        rf_push    = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q >= INIT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 16'd1;
                end
            end

            ST_IDLE: begin
                if (PI_AddrReq &&
                    ((PI_RNW && rf_cnt_q == 5'd0) ||
                     (!PI_RNW && !PI_WrFIFO_Flush && wf_cnt_q >= req_len))) begin
                    ack_d   = 1'b1;
                    len_d   = req_len;
                    mask_d  = req_mask;
                    off_d   = req_off;
                    base_d  = req_word & ~AW'(req_mask);
                    beat_d  = 5'd0;
                    state_d = PI_RNW ? ST_RD_FETCH : ST_WR_DRAIN;
                end
            end

            ST_RD_FETCH: begin
                if (PI_RdFIFO_Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    // issue side: one RAM read per beat
                    if (beat_q < len_q) begin
                        ram_re    = 1'b1;
                        rdv_d     = 1'b1;
                        rdv_tag_d = off_q & mask_q;
                        off_d     = off_q + 4'd1;
                        beat_d    = beat_q + 5'd1;
                    end
                    // return side: RAM data lands in the FIFO a cycle later
                    rf_push = rdv_q;
                    if (beat_q == len_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WR_DRAIN: begin
                if (PI_WrFIFO_Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    ram_we = !MPMC_Rst;
                    wf_pop = 1'b1;
                    off_d  = off_q + 4'd1;
                    beat_d = beat_q + 5'd1;
                    if (beat_q == len_q - 5'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    //--------------------------------------------------------------------------
    // FIFO bookkeeping; flush wins over any same-cycle push or pop
    //--------------------------------------------------------------------------
    always_comb begin
        wf_push = PI_WrFIFO_Push && (wf_cnt_q != 5'(FIFO_DEPTH)) && !PI_WrFIFO_Flush;
        if (PI_WrFIFO_Flush) begin
            wf_wptr_d = 4'd0;
            wf_rptr_d = 4'd0;
            wf_cnt_d  = 5'd0;
        end else begin
            wf_wptr_d = wf_wptr_q + 4'(wf_push);
            wf_rptr_d = wf_rptr_q + 4'(wf_pop);
            wf_cnt_d  = wf_cnt_q + 5'(wf_push) - 5'(wf_pop);
        end

        rf_pop = PI_RdFIFO_Pop && (rf_cnt_q != 5'd0) && !PI_RdFIFO_Flush;
        if (PI_RdFIFO_Flush) begin
            rf_wptr_d = 4'd0;
            rf_rptr_d = 4'd0;
            rf_cnt_d  = 5'd0;
        end else begin
            rf_wptr_d = rf_wptr_q + 4'(rf_push);
            rf_rptr_d = rf_rptr_q + 4'(rf_pop);
            rf_cnt_d  = rf_cnt_q + 5'(rf_push) - 5'(rf_pop);
        end
    end

    always_ff @(posedge MPMC_Clk) begin
        if (MPMC_Rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 16'd0;
            ack_q      <= 1'b0;
            len_q      <= 5'd1;
            beat_q     <= 5'd0;
            mask_q     <= 4'd0;
            off_q      <= 4'd0;
            base_q     <= '0;
            rdv_q      <= 1'b0;
            rdv_tag_q  <= 4'd0;
            wf_wptr_q  <= 4'd0;
            wf_rptr_q  <= 4'd0;
            wf_cnt_q   <= 5'd0;
            rf_wptr_q  <= 4'd0;
            rf_rptr_q  <= 4'd0;
            rf_cnt_q   <= 5'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ack_q      <= ack_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            mask_q     <= mask_d;
            off_q      <= off_d;
            base_q     <= base_d;
            rdv_q      <= rdv_d;
            rdv_tag_q  <= rdv_tag_d;
            wf_wptr_q  <= wf_wptr_d;
            wf_rptr_q  <= wf_rptr_d;
            wf_cnt_q   <= wf_cnt_d;
            rf_wptr_q  <= rf_wptr_d;
            rf_rptr_q  <= rf_rptr_d;
            rf_cnt_q   <= rf_cnt_d;
        end
    end

    // Write FIFO storage needs no reset: the count decides what is valid.
    always_ff @(posedge MPMC_Clk) begin
        if (wf_push) begin
            wf_mem[wf_wptr_q] <= {PI_WrFIFO_BE, PI_WrFIFO_Data};
        end
    end

    // Read FIFO storage is cleared on reset so the head reads 0 out of reset.
    always_ff @(posedge MPMC_Clk) begin
        if (MPMC_Rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rf_mem_q[i] <= '0;
            end
        end else if (rf_push) begin
            rf_mem_q[rf_wptr_q] <= {rdv_tag_q, ram_rd_data};
        end
    end

    //--------------------------------------------------------------------------
    // Byte-lane RAMs: one array per lane gives clean byte-enable inference.
    // Contents are not reset.
    //--------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];
            logic [7:0] lane_rd_q;
            always_ff @(posedge MPMC_Clk) begin
                if (ram_we && wf_head_be[gi]) begin
                    lane_mem[ram_addr] <= wf_head_data[gi*8 +: 8];
                end
                if (ram_re) begin
                    lane_rd_q <= lane_mem[ram_addr];
                end
            end
            assign ram_rd_data[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign rf_head              = rf_mem_q[rf_rptr_q];
    assign PI_AddrAck           = ack_q;
    assign PI_InitDone          = (state_q != ST_INIT);
    assign PI_WrFIFO_AlmostFull = (wf_cnt_q >= 5'd15);
    assign PI_WrFIFO_Empty      = (wf_cnt_q == 5'd0);
    assign PI_RdFIFO_Empty      = (rf_cnt_q == 5'd0);
    assign PI_RdFIFO_Data       = rf_head[DW-1:0];
    assign PI_RdFIFO_RdWdAddr   = C_PI_RDWDADDR_WIDTH'(rf_head[RF_W-1:DW]);
    assign PI_RdFIFO_Latency    = 2'd0;

endmodule

// File: doc/npi_mem_responder.md
# npi_mem_responder

Single-clock NPI target that answers MPMC-style personality-interface (PI_*) transactions from an NPI initiator such as the dual XCL bridge, backed by an internal byte-enabled block RAM. It provides the memory-controller end of the NPI link for on-chip scratch memory and for closed-loop simulation of XCL/NPI masters without an MPMC. It supports word, 4-word and 8-word cache-line transfers with critical-word-first wrap, and 16-word bursts, through 16-deep write and read FIFOs.

## Interface
- C_PI_ADDR_WIDTH, 32, byte address width
- C_PI_DATA_WIDTH, 32, data width; fixed at 32
- C_PI_BE_WIDTH, 4, byte enables
- C_PI_RDWDADDR_WIDTH, 4, read word-address tag width
- C_PI_BASEADDR, 32'hc0000000, byte address mapped to RAM word 0
- C_MEM_AWIDTH, 10, log2 of RAM depth in words
- C_INIT_CYCLES, 16, cycles after reset before PI_InitDone

Ports:
- MPMC_Clk  in  1  sole clock
- MPMC_Rst  in  1  synchronous active-high reset
- PI_Addr  in  32  byte address
- PI_AddrReq  in  1  request, held until ack
- PI_AddrAck  out  1  one-cycle accept pulse
- PI_RNW  in  1  1 = read
- PI_RdModWr  in  1  ignored; BE always honoured
- PI_Size  in  4  0 word, 1 4-word line, 2 8-word line, 3 16-word burst
- PI_InitDone  out  1  ready
- PI_WrFIFO_Data  in  32  write data
- PI_WrFIFO_BE  in  4  byte enables
- PI_WrFIFO_Push  in  1  push write word
- PI_WrFIFO_AlmostFull  out  1  count ≥ 15
- PI_WrFIFO_Empty  out  1  count = 0
- PI_WrFIFO_Flush  in  1  clear write FIFO
- PI_RdFIFO_Data  out  32  head word (first-word-fall-through)
- PI_RdFIFO_RdWdAddr  out  4  word offset of head word
- PI_RdFIFO_Pop  in  1  pop head
- PI_RdFIFO_Empty  out  1  count = 0
- PI_RdFIFO_Flush  in  1  clear read FIFO
- PI_RdFIFO_Latency  out  2  constant 2'd0

## Operation
- States: INIT, IDLE, RD_FETCH, WR_DRAIN.
- INIT: counts C_INIT_CYCLES, then IDLE with PI_InitDone=1 (stays 1 until reset). AddrReq ignored in INIT.
- Burst length N: Size 0→1, 1→4, 2→8, 3→16; Size 4..15 treated as 16.
- Word index W = ((PI_Addr − C_PI_BASEADDR)>>2) mod 2^C_MEM_AWIDTH.
- Line/burst ordering: Size 0 one word at W, tag 0. Size 1/2: start at W, increment within the N-aligned line, wrap to line base; tag = offset in line. Size 3+: start at W rounded down to 16, linear, tag = offset 0..15. RAM index wraps modulo depth.
- IDLE read accept: AddrReq & RNW & RdFIFO empty. Write accept: AddrReq & !RNW & wr count ≥ N. Otherwise wait, no ack. Size latched at accept.
- RD_FETCH: one RAM read per cycle for N cycles; data+tag written into read FIFO one cycle later; back to IDLE after the Nth write.
- WR_DRAIN: pops one word per cycle, writes RAM byte lanes where BE=1; back to IDLE after N words.
- Push while wr FIFO full (16): word dropped. Pop while rd FIFO empty: ignored, data/tag hold.
- WrFIFO_Flush: wr FIFO count→0 next cycle; in WR_DRAIN aborts to IDLE, words already written stay. RdFIFO_Flush: rd FIFO cleared; in RD_FETCH aborts to IDLE, in-flight RAM word discarded. Flush overrides same-cycle push/pop.
- Simultaneous push and internal pop (or fetch write and Pop): count unchanged, both happen.

## Timing
- Reset values: AddrAck 0, InitDone 0, WrFIFO_Empty 1, AlmostFull 0, RdFIFO_Empty 1, RdFIFO_Data 0, RdWdAddr 0, Latency 0; state INIT; FIFOs empty; RAM contents preserved.
- Reset mid-transaction: abort, return to INIT, InitDone low C_INIT_CYCLES again.
- Read: cycle 0 accept condition true; cycle 1 AddrAck=1, RAM read 1; reads cycles 1..N; FIFO writes 2..N+1; RdFIFO_Empty=0 from cycle 3; IDLE in cycle N+2.
- Write: cycle 0 accept; cycle 1 AddrAck=1, first RAM write; writes cycles 1..N; IDLE in cycle N+1.
- Empty/AlmostFull combinational from registered counts; Data/RdWdAddr valid while Empty=0, Pop advances head at edge.
- No second ack possible in cycle after an ack.

## Test plan
- Reset 16 cycles then release → InitDone rises cycle 16; AddrReq at cycle 5 gets no ack until after InitDone.
- Push 0x11111111 BE 4'b0011 to base+0x8 (Size 0), then read Size 0 → RAM word 2 lower half updated only; read returns merged word, tag 0, Empty low 3 cycles after accept.
- Write words 0..7 to line at base+0x20 (Size 2), read Size 2 at base+0x34 → data order words 5,6,7,0..4, tags 5,6,7,0,1,2,3,4.
- Size 1 write request with 3 words pushed → no ack; 4th push → ack next cycle; WrFIFO_Empty=1 after 4 drain cycles.
- 17 pushes with no request → AlmostFull at 15, 17th dropped, count 16; Flush → Empty=1 next cycle.
- Size 3 read, RdFIFO_Flush at cycle 6 → return to IDLE, Empty=1, later Size 0 read returns correct word; MPMC_Rst mid write drain → InitDone low, FIFOs empty.
